// File: rtl/cpu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pipe_pkg
// Shared pipeline definitions used by the hazard detection logic:
//   hdu_state_t : hazard unit FSM state encoding
//   REG_ADDR_W  : default register address width
//   NOP_INSTR   : instruction word loaded into ID/EX when a bubble is injected
// ---------------------------------------------------------------------------
package cpu_pipe_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hdu_state_t;

    localparam int REG_ADDR_W = 4;

    // Encoding the ID/EX register takes when idex_bubble is asserted.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage : cpu_pipe_pkg

// File: rtl/hdu_src_match.sv
// ---------------------------------------------------------------------------
// hdu_src_match
// Compares one decode-stage source register against the execute-stage
// destination. The match only counts when the source is actually read.
// With ZERO_REG_HARD=1 register 0 is hardwired and never matches.
//
// Ports:
//   raddr   in  ADDR_W  decode source register address
//   src_use in  1       decode instruction reads this source
//   wreg    in  ADDR_W  execute destination register
//   match   out 1       source depends on the execute destination
// ---------------------------------------------------------------------------
module hdu_src_match
    import cpu_pipe_pkg::*;
#(
    parameter int ADDR_W        = REG_ADDR_W,
    parameter int ZERO_REG_HARD = 0
) (
    input  logic [ADDR_W-1:0] raddr,
    input  logic              src_use,
    input  logic [ADDR_W-1:0] wreg,
    output logic              match
);

    logic wreg_live;

    // Writes to a hardwired zero register never produce a real value.
    assign wreg_live = (ZERO_REG_HARD == 0) || (wreg != '0);
    assign match     = src_use && (raddr == wreg) && wreg_live;

endmodule : hdu_src_match

// File: rtl/hdu_multicycle.sv
// ---------------------------------------------------------------------------
// hdu_multicycle
// Load-use hazard detection unit with a programmable stall length.
// A decode instruction that reads the destination of a load in execute
// holds PC and IF/ID and bubbles ID/EX for LOAD_LAT cycles. Execute-stage
// redirects take priority and flush IF/ID instead.
//
// Optional build macro: HDU_PERF_CNT_EN adds saturating performance
// counters stall_cycles and hazard_events.
//
// Ports:
//   clk           in  1       pipeline clock
//   rst_n         in  1       asynchronous active-low reset
//   d_raddr1/2    in  ADDR_W  decode source registers
//   d_use1/2      in  1       decode instruction reads raddr1/raddr2
//   d_valid       in  1       decode slot holds a real instruction
//   e_is_load     in  1       execute instruction is a load
//   e_wreg        in  ADDR_W  execute destination register
//   e_redirect    in  1       execute resolves taken branch / JR / jump
//   pc_stall      out 1       hold PC
//   ifid_stall    out 1       hold IF/ID
//   idex_bubble   out 1       load NOP into ID/EX
//   ifid_flush    out 1       clear IF/ID
//   stall_busy    out 1       registered, high while in STALL
//   stall_cycles  out 32      (HDU_PERF_CNT_EN) cycles with pc_stall high
//   hazard_events out 16      (HDU_PERF_CNT_EN) stall entries from IDLE
//
// Legal parameters: 1 <= LOAD_LAT <= 15, 2**CNT_W > LOAD_LAT.
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | no stall in progress; hazard or redirect handled in-cycle
// STALL | counting down remaining load-use stall cycles in cnt
// ---------------------------------------------------------------------------
module hdu_multicycle
    import cpu_pipe_pkg::*;
#(
    parameter int ADDR_W        = REG_ADDR_W,
    parameter int LOAD_LAT      = 1,
    parameter int CNT_W         = 4,
    parameter int ZERO_REG_HARD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] d_raddr1,
    input  logic [ADDR_W-1:0] d_raddr2,
    input  logic              d_use1,
    input  logic              d_use2,
    input  logic              d_valid,
    input  logic              e_is_load,
    input  logic [ADDR_W-1:0] e_wreg,
    input  logic              e_redirect,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              stall_busy
`ifdef HDU_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       hazard_events
`endif
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    hdu_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             match1;
    logic             match2;
    logic             hz;
    logic             stall_entry;

    hdu_src_match #(
        .ADDR_W        (ADDR_W),
        .ZERO_REG_HARD (ZERO_REG_HARD)
    ) u_match1 (
        .raddr   (d_raddr1),
        .src_use (d_use1),
        .wreg    (e_wreg),
        .match   (match1)
    );

    hdu_src_match #(
        .ADDR_W        (ADDR_W),
        .ZERO_REG_HARD (ZERO_REG_HARD)
    ) u_match2 (
        .raddr   (d_raddr2),
        .src_use (d_use2),
        .wreg    (e_wreg),
        .match   (match2)
    );

    // Pure input decode; cnt deliberately does not feed the hazard term.
    assign hz = d_valid && e_is_load && (match1 || match2);

    // New load-use stall starting from IDLE (redirect suppresses it).
    assign stall_entry = (state == IDLE) && !e_redirect && hz;

    // -----------------------------------------------------------------------
    // Control outputs. Gated by rst_n so nothing asserts during reset even
    // when the hazard inputs are active.
    // -----------------------------------------------------------------------
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (rst_n) begin
            if (e_redirect) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if ((state == STALL) || hz) begin
                // In STALL the load has already left execute, so hz is moot.
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State, counter and registered busy flag. The IDLE hazard cycle is the
    // first stall cycle, so STALL covers the remaining LOAD_LAT-1 cycles.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            stall_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (stall_entry && (LOAD_LAT > 1)) begin
                        state      <= STALL;
                        cnt        <= CNT_INIT;
                        stall_busy <= 1'b1;
                    end
                end
                STALL: begin
                    if (e_redirect || (cnt == CNT_ONE)) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        stall_busy <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    stall_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef HDU_PERF_CNT_EN
    // Saturating event counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles  <= '0;
            hazard_events <= '0;
        end else begin
            if (pc_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (stall_entry && (hazard_events != '1)) begin
                hazard_events <= hazard_events + 16'd1;
            end
        end
    end
`endif

endmodule : hdu_multicycle
